// File: rtl/decimal_req_arbiter.sv
// rtl/decimal_req_arbiter.sv - round-robin arbiter with hold-time limit and registered one-hot/binary grant
module decimal_req_arbiter #(
   parameter int N        = 10,
   parameter int IDX_W    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] owner, owner_nx;
   logic [IDX_W-1:0] ptr, ptr_nx;
   logic [7:0]       hold_cnt, hold_nx;
   logic [N-1:0]     cand;
   logic [N-1:0]     grant_nx;
   logic             own_req;
   logic [IDX_W-1:0] sel;
   logic             sel_found;
   logic             load;

   // Candidates exclude the current owner so a timeout rotation never re-picks it.
   always_comb begin
      cand    = req;
      own_req = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (state == GRANT && owner == IDX_W'(i)) begin
            cand[i] = 1'b0;
            own_req = req[i];
         end
      end
   end

   always_comb begin
      int j;
      sel       = '0;
      sel_found = 1'b0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!sel_found && cand[j]) begin
            sel_found = 1'b1;
            sel       = IDX_W'(j);
         end
      end
   end

   always_comb begin
      state_nx = state;
      owner_nx = owner;
      ptr_nx   = ptr;
      hold_nx  = hold_cnt;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) load = 1'b1;
         end
         GRANT: begin
            if (!own_req) begin
               if (sel_found) begin
                  load = 1'b1;
               end else begin
                  state_nx = IDLE;
                  hold_nx  = '0;
               end
            end else if (hold_cnt < 8'(MAX_HOLD - 1)) begin
               hold_nx = hold_cnt + 8'd1;
            end else begin
               // Timeout: rotate if anyone else waits, otherwise keep the grant seamlessly.
               hold_nx = '0;
               if (sel_found) load = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (load) begin
         state_nx = GRANT;
         owner_nx = sel;
         hold_nx  = '0;
         ptr_nx   = (sel == IDX_W'(N - 1)) ? '0 : sel + 1'b1;
      end
   end

   always_comb begin
      grant_nx = '0;
      for (int i = 0; i < N; i++) begin
         grant_nx[i] = (state_nx == GRANT) && (owner_nx == IDX_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= '0;
         ptr         <= '0;
         hold_cnt    <= '0;
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
      end else begin
         state       <= state_nx;
         owner       <= owner_nx;
         ptr         <= ptr_nx;
         hold_cnt    <= hold_nx;
         grant       <= grant_nx;
         grant_idx   <= (state_nx == GRANT) ? owner_nx : '0;
         grant_valid <= (state_nx == GRANT);
      end
   end

endmodule

// File: tb/tb_decimal_req_arbiter.sv
// tb/tb_decimal_req_arbiter.sv - scoreboard bench for decimal_req_arbiter against a queue-based reference model
module tb_decimal_req_arbiter;

   localparam int N        = 10;
   localparam int IDX_W    = 4;
   localparam int MAX_HOLD = 8;

   typedef struct {
      logic [N-1:0]     g;
      logic [IDX_W-1:0] idx;
      logic             v;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req;
   logic [N-1:0]     grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;

   int   m_owner = -1;
   int   m_ptr   = 0;
   int   m_hold  = 0;

   decimal_req_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Round-robin order as an explicit list: ptr, ptr+1, ..., wrapping; first requester not skipped wins.
   function automatic int pick(input logic [N-1:0] r, input int p, input int skip);
      int order[$];
      for (int k = 0; k < N; k++) order.push_back((p + k) % N);
      foreach (order[i]) begin
         if (order[i] != skip && r[order[i]]) return order[i];
      end
      return -1;
   endfunction

   function automatic void take(input int who);
      m_owner = who;
      m_hold  = 0;
      m_ptr   = (who + 1) % N;
   endfunction

   function automatic void model(input logic rb, input logic [N-1:0] r);
      int nxt;
      if (!rb) begin
         m_owner = -1;
         m_ptr   = 0;
         m_hold  = 0;
      end else if (m_owner < 0) begin
         nxt = pick(r, m_ptr, -1);
         if (nxt >= 0) take(nxt);
      end else if (!r[m_owner]) begin
         nxt = pick(r, m_ptr, -1);
         if (nxt >= 0) take(nxt);
         else m_owner = -1;
      end else if (m_hold < MAX_HOLD - 1) begin
         m_hold++;
      end else begin
         nxt = pick(r, m_ptr, m_owner);
         if (nxt >= 0) take(nxt);
         else m_hold = 0;
      end
   endfunction

   task automatic step(input logic rb, input logic [N-1:0] r);
      exp_t e;
      @(posedge clk);
      #2;
      rst_n = rb;
      req   = r;
      model(rb, r);
      e.v   = (m_owner >= 0);
      e.g   = e.v ? (N'(1) << m_owner) : '0;
      e.idx = e.v ? IDX_W'(m_owner) : '0;
      q.push_back(e);
   endtask

   task automatic hold_req(input logic [N-1:0] r, input int cycles);
      for (int c = 0; c < cycles; c++) step(1'b1, r);
   endtask

   task automatic do_reset(input int cycles);
      for (int c = 0; c < cycles; c++) step(1'b0, '0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (grant === e.g && grant_idx === e.idx && grant_valid === e.v) begin
               passed++;
            end else begin
               $display("FAIL grant t=%0t: got grant=%b idx=%0d valid=%b, expected grant=%b idx=%0d valid=%b",
                        $time, grant, grant_idx, grant_valid, e.g, e.idx, e.v);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] r;
      int           len;
      rst_n = 1'b0;
      req   = '0;

      do_reset(2);
      hold_req(10'b0000001000, 3);
      hold_req('0, 2);

      do_reset(1);
      hold_req('1, 10 * MAX_HOLD + 12);

      do_reset(1);
      hold_req(10'b0000000100, 30);

      do_reset(1);
      hold_req(10'b0000100000, 3);
      hold_req(10'b0010100100, 1);
      hold_req(10'b0010000100, 4);
      hold_req(10'b0000000100, 3);
      hold_req('0, 1);

      do_reset(1);
      hold_req(10'b0000010000, 2);
      hold_req(10'b0000010001, 12);
      hold_req(10'b0000000001, 2);

      do_reset(1);
      hold_req('1, 6 * MAX_HOLD + 3);
      do_reset(1);
      hold_req('1, 5);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0:       r = N'($urandom);
            1:       r = N'($urandom & $urandom);
            2:       r = N'(1) << $urandom_range(0, N - 1);
            default: r = '0;
         endcase
         len = $urandom_range(1, 12);
         if ($urandom_range(0, 40) == 0) do_reset(1);
         hold_req(r, len);
      end

      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (q.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending expectations, expected 0", q.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
